// File: rtl/spi_regbank_sync.sv
// SPI-programmed register bank with set/clear/toggle frames and in-frame readback.
// Every SPI pin is oversampled in clk; no logic runs on SCK or CS.
module spi_regbank_sync #(
  parameter int                   NREG          = 16,
  parameter int                   RW            = 4,
  parameter int                   ADDR_BITS     = 8,
  parameter int                   BASE_ADDR     = 12,
  parameter int                   SOFT_RST_ADDR = 11,
  parameter logic [NREG*RW-1:0]   RESET_VAL     = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               spi_clk,
  input  logic               spi_cs,
  input  logic               spi_special,
  input  logic               spi_din,
  output logic               spi_dout,
  output logic [NREG*RW-1:0] regs,
  output logic               wr_stb,
  output logic               frame_err
);

  localparam int                  FRAME     = ADDR_BITS + 2*RW;
  localparam int                  CW        = $clog2(FRAME + 2);
  localparam int                  AW1       = ADDR_BITS + 1;
  localparam logic [AW1-1:0]      BASE_EXT  = AW1'(BASE_ADDR);
  localparam logic [ADDR_BITS-1:0] SOFT_ADDR = ADDR_BITS'(SOFT_RST_ADDR);
  localparam logic [CW-1:0]       CNT_FRAME = CW'(FRAME);
  localparam logic [CW-1:0]       CNT_SAT   = CW'(FRAME + 1);
  localparam logic [CW-1:0]       CNT_ADDR  = CW'(ADDR_BITS);

  typedef enum logic [1:0] {ST_IDLE, ST_FRAME, ST_ABORT} state_t;

  logic [2:0]           sck_sr, cs_sr, sp_sr;
  logic [1:0]           din_sr;
  logic [1:0]           warm_q;
  logic                 sync_ok;
  logic                 sck_rise, sck_fall, cs_rise, cs_fall, sp_rise;
  logic                 frame_start, frame_end, abort, in_frame;
  logic                 commit_req, err_req;
  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q;
  logic [FRAME-1:0]     shift_q;
  logic [2*RW-1:0]      shadow_q;
  logic [RW-1:0]        rd_val;
  logic [ADDR_BITS-1:0] rd_addr;
  logic                 commit_q, err_q;
  logic [FRAME-1:0]     word_q;
  logic [ADDR_BITS-1:0] waddr;
  logic [RW-1:0]        w_set, w_clr;
  logic [NREG-1:0]      w_hit;
  logic [RW-1:0]        reg_q [NREG];

  function automatic logic [RW-1:0] upd(input logic [RW-1:0] r,
                                        input logic [RW-1:0] s,
                                        input logic [RW-1:0] c);
    logic [RW-1:0] t;
    t = s & c;
    if (|t) return r ^ t;
    return (r | s) & ~c;
  endfunction

  // Stage [0],[1] synchronise; stage [2] is history for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sck_sr <= 3'b000;
      cs_sr  <= 3'b111;
      sp_sr  <= 3'b111;
      din_sr <= 2'b00;
      warm_q <= 2'd0;
    end else begin
      sck_sr <= {sck_sr[1:0], spi_clk};
      cs_sr  <= {cs_sr[1:0], spi_cs};
      sp_sr  <= {sp_sr[1:0], spi_special};
      din_sr <= {din_sr[0], spi_din};
      if (warm_q != 2'd3) warm_q <= warm_q + 2'd1;
    end
  end

  // Edges are masked until real pin levels reach the history stage, so a CS
  // already low when reset lifts is not mistaken for a frame start.
  assign sync_ok  = (warm_q == 2'd3);
  assign sck_rise = sync_ok &  sck_sr[1] & ~sck_sr[2];
  assign sck_fall = sync_ok & ~sck_sr[1] &  sck_sr[2];
  assign cs_rise  = sync_ok &  cs_sr[1]  & ~cs_sr[2];
  assign cs_fall  = sync_ok & ~cs_sr[1]  &  cs_sr[2];
  assign sp_rise  = sync_ok &  sp_sr[1]  & ~sp_sr[2];

  assign frame_start = cs_fall & ~sp_sr[1];
  assign frame_end   = cs_rise & (state_q != ST_IDLE);
  assign abort       = (state_q == ST_FRAME) & sp_rise & ~cs_sr[1];
  assign in_frame    = (state_q == ST_FRAME) & ~cs_sr[1] & ~sp_sr[1];
  assign commit_req  = frame_end & (state_q == ST_FRAME) & ~sp_sr[1] & (cnt_q == CNT_FRAME);
  assign err_req     = frame_end & ((state_q == ST_ABORT) | (cnt_q != CNT_FRAME));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (frame_start)    state_d = ST_FRAME;
    else if (frame_end) state_d = ST_IDLE;
    else if (abort)     state_d = ST_ABORT;
  end

  // CS rise has priority over any SCK edge seen in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      shift_q  <= '0;
      shadow_q <= '0;
      spi_dout <= 1'b0;
    end else if (frame_start) begin
      cnt_q    <= '0;
      shift_q  <= '0;
      shadow_q <= '0;
      spi_dout <= 1'b0;
    end else if (abort) begin
      cnt_q <= CNT_SAT;
    end else if (in_frame && sck_rise) begin
      shift_q <= {shift_q[FRAME-2:0], din_sr[1]};
      if (cnt_q != CNT_SAT) cnt_q <= cnt_q + CW'(1);
    end else if (in_frame && sck_fall) begin
      if (cnt_q == CNT_ADDR) begin
        shadow_q <= {rd_val, {RW{1'b0}}};
        spi_dout <= rd_val[RW-1];
      end else begin
        shadow_q <= {shadow_q[2*RW-2:0], 1'b0};
        spi_dout <= shadow_q[2*RW-2];
      end
    end
  end

  // Compare in ADDR_BITS+1 bits so BASE_ADDR+NREG never wraps into low addresses.
  assign rd_addr = shift_q[ADDR_BITS-1:0];

  always_comb begin
    rd_val = '0;
    for (int i = 0; i < NREG; i++) begin
      if ({1'b0, rd_addr} == BASE_EXT + AW1'(i)) rd_val = reg_q[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      commit_q <= 1'b0;
      err_q    <= 1'b0;
      word_q   <= '0;
    end else begin
      commit_q <= commit_req;
      err_q    <= err_req;
      if (commit_req) word_q <= shift_q;
    end
  end

  assign waddr = word_q[FRAME-1 -: ADDR_BITS];
  assign w_set = word_q[RW-1:0];
  assign w_clr = word_q[2*RW-1:RW];

  always_comb begin
    w_hit = '0;
    for (int i = 0; i < NREG; i++) begin
      w_hit[i] = ({1'b0, waddr} == BASE_EXT + AW1'(i));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) reg_q[i] <= RESET_VAL[i*RW +: RW];
      wr_stb    <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      wr_stb    <= 1'b0;
      frame_err <= err_q;
      if (commit_q) begin
        if (waddr == SOFT_ADDR) begin
          for (int i = 0; i < NREG; i++) reg_q[i] <= RESET_VAL[i*RW +: RW];
          wr_stb <= 1'b1;
        end else if (|w_hit) begin
          for (int i = 0; i < NREG; i++) begin
            if (w_hit[i]) reg_q[i] <= upd(reg_q[i], w_set, w_clr);
          end
          wr_stb <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    regs = '0;
    for (int i = 0; i < NREG; i++) regs[i*RW +: RW] = reg_q[i];
  end

endmodule

// File: tb/tb_spi_regbank_sync.sv
// Bench for spi_regbank_sync: directed frames plus randomized frames against
// a register-array model of the bank.
module tb_spi_regbank_sync;

  localparam int          NREG = 16;
  localparam int          RW   = 4;
  localparam int          AB   = 8;
  localparam int          FRM  = 16;
  localparam int          BASE = 12;
  localparam int          SOFT = 11;
  localparam int          HALF = 6;
  localparam logic [63:0] RV   = 64'h0000_0000_0000_F000;

  logic        clk = 1'b0;
  logic        rst_n, spi_clk, spi_cs, spi_special, spi_din;
  logic        spi_dout, wr_stb, frame_err;
  logic [63:0] regs;

  int   n_cmp   = 0;
  int   n_bad   = 0;
  int   wr_cnt  = 0;
  int   err_cnt = 0;
  bit   chk_en  = 1'b0;
  logic [3:0]  m_reg [NREG];
  logic [31:0] rb;

  always #5 clk = ~clk;

  spi_regbank_sync #(
    .NREG(NREG), .RW(RW), .ADDR_BITS(AB), .BASE_ADDR(BASE),
    .SOFT_RST_ADDR(SOFT), .RESET_VAL(RV)
  ) dut (
    .clk(clk), .rst_n(rst_n), .spi_clk(spi_clk), .spi_cs(spi_cs),
    .spi_special(spi_special), .spi_din(spi_din), .spi_dout(spi_dout),
    .regs(regs), .wr_stb(wr_stb), .frame_err(frame_err)
  );

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < NREG; i++) m_reg[i] = RV[i*4 +: 4];
  endfunction

  function automatic logic [63:0] model_flat();
    logic [63:0] f;
    f = '0;
    for (int i = 0; i < NREG; i++) f[i*4 +: 4] = m_reg[i];
    return f;
  endfunction

  function automatic bit in_rng(input int a);
    return (a >= BASE) && (a < BASE + NREG);
  endfunction

  // Strobe cycles are counted continuously; registers are compared every idle cycle.
  always @(negedge clk) begin
    if (wr_stb === 1'b1) wr_cnt++;
    if (frame_err === 1'b1) err_cnt++;
    if (chk_en) begin
      checkOutput("regs_idle", regs, model_flat());
      checkOutput("strobes_idle", {62'd0, wr_stb, frame_err}, 64'd0);
    end
  end

  // Mode-0 master: drive on falling SCK, sample MISO on rising SCK.
  task automatic applyStimulus(input logic [31:0] word, input int nbits, input int abort_at,
                               input int rst_at, input bit unq, output logic [31:0] miso);
    miso   = '0;
    chk_en = 1'b0;
    @(negedge clk);
    spi_special = unq;
    repeat (2) @(negedge clk);
    spi_cs  = 1'b0;
    spi_din = word[nbits-1];
    repeat (HALF) @(negedge clk);
    for (int k = 0; k < nbits; k++) begin
      if (k == abort_at) begin
        spi_special = 1'b1;
        repeat (HALF) @(negedge clk);
      end
      if (k == rst_at) begin
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (HALF) @(negedge clk);
      end
      spi_clk = 1'b1;
      miso = {miso[30:0], spi_dout};
      repeat (HALF) @(negedge clk);
      spi_clk = 1'b0;
      if (k + 1 < nbits) spi_din = word[nbits-2-k];
      repeat (HALF) @(negedge clk);
    end
    spi_cs = 1'b1;
    repeat (HALF) @(negedge clk);
    spi_special = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task automatic run_frame(input string tag, input logic [31:0] word, input int nbits,
                           input int abort_at, input int rst_at, input bit unq,
                           output logic [31:0] miso);
    logic [31:0] exp_m, mask;
    logic [3:0]  s, c, t;
    int          addr, exp_wr, exp_err;
    bit          b;
    addr  = int'((word >> (nbits - 8)) & 32'hFF);
    exp_m = '0;
    mask  = '0;
    for (int k = 0; k < nbits; k++) begin
      b = 1'b0;
      if (k >= AB && k < AB + RW && in_rng(addr)) b = m_reg[addr-BASE][RW-1-(k-AB)];
      if (rst_at >= 0 && k >= rst_at) b = 1'b0;
      exp_m = {exp_m[30:0], b};
      mask  = {mask[30:0], (abort_at < 0 || k < abort_at)};
    end
    wr_cnt  = 0;
    err_cnt = 0;
    applyStimulus(word, nbits, abort_at, rst_at, unq, miso);
    exp_wr  = 0;
    exp_err = 0;
    if (rst_at >= 0) begin
      model_reset();
    end else if (!unq) begin
      if (abort_at >= 0 || nbits != FRM) begin
        exp_err = 1;
      end else if (addr == SOFT) begin
        model_reset();
        exp_wr = 1;
      end else if (in_rng(addr)) begin
        s = word[3:0];
        c = word[7:4];
        t = s & c;
        m_reg[addr-BASE] = (|t) ? (m_reg[addr-BASE] ^ t) : ((m_reg[addr-BASE] | s) & ~c);
        exp_wr = 1;
      end
    end
    if (!unq) checkOutput({tag, "_miso"}, 64'(miso & mask), 64'(exp_m & mask));
    checkOutput({tag, "_wr_stb"}, 64'(wr_cnt), 64'(exp_wr));
    checkOutput({tag, "_frame_err"}, 64'(err_cnt), 64'(exp_err));
    chk_en = 1'b1;
  endtask

  initial begin
    logic [7:0]  ra, rd;
    logic [31:0] w;
    int          kind, nb, ab_at;
    rst_n = 1'b0; spi_clk = 1'b0; spi_cs = 1'b1; spi_special = 1'b1; spi_din = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    checkOutput("rst_regs", regs, 64'h0000_0000_0000_F000);
    checkOutput("rst_reg3", 64'(regs[15:12]), 64'hF);
    checkOutput("rst_model", model_flat(), 64'h0000_0000_0000_F000);
    checkOutput("rst_dout", 64'(spi_dout), 64'd0);
    checkOutput("rst_strobes", {62'd0, wr_stb, frame_err}, 64'd0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk_en = 1'b1;

    run_frame("t2a", 32'h0C05, 16, -1, -1, 1'b0, rb);
    checkOutput("t2a_reg0", 64'(regs[3:0]), 64'h5);
    checkOutput("t2a_model", 64'(m_reg[0]), 64'h5);
    run_frame("t2b", 32'h0C30, 16, -1, -1, 1'b0, rb);
    checkOutput("t2b_reg0", 64'(regs[3:0]), 64'h4);

    run_frame("t3a", 32'h0C66, 16, -1, -1, 1'b0, rb);
    checkOutput("t3a_reg0", 64'(regs[3:0]), 64'h2);
    checkOutput("t3a_model", 64'(m_reg[0]), 64'h2);
    run_frame("t3b", 32'h0C00, 16, -1, -1, 1'b0, rb);
    checkOutput("t3b_readback", 64'(rb[15:0]), 64'h0020);

    run_frame("t4_15b", 32'h060F, 15, -1, -1, 1'b0, rb);
    run_frame("t4_17b", 32'h18FF, 17, -1, -1, 1'b0, rb);
    run_frame("t4_abort", 32'h0C0F, 16, 12, -1, 1'b0, rb);
    checkOutput("t4_reg0", 64'(regs[3:0]), 64'h2);
    run_frame("t4_unq", 32'h0C0F, 16, -1, -1, 1'b1, rb);

    run_frame("t5a", 32'h0D0F, 16, -1, -1, 1'b0, rb);
    run_frame("t5b", 32'h1B03, 16, -1, -1, 1'b0, rb);
    run_frame("t5_soft", 32'h0B00, 16, -1, -1, 1'b0, rb);
    checkOutput("t5_soft_regs", regs, 64'h0000_0000_0000_F000);
    run_frame("t5_far", 32'h40FF, 16, -1, -1, 1'b0, rb);
    run_frame("t5_edge", 32'h1CFF, 16, -1, -1, 1'b0, rb);
    checkOutput("t5_far_regs", regs, 64'h0000_0000_0000_F000);

    run_frame("t6a", 32'h0D05, 16, -1, -1, 1'b0, rb);
    run_frame("t6_rst", 32'h0C0F, 16, -1, 9, 1'b0, rb);
    checkOutput("t6_regs", regs, 64'h0000_0000_0000_F000);
    run_frame("t6b", 32'h0C0F, 16, -1, -1, 1'b0, rb);
    checkOutput("t6b_reg0", 64'(regs[3:0]), 64'hF);

    for (int n = 0; n < 70; n++) begin
      kind = $urandom_range(0, 19);
      case ($urandom_range(0, 9))
        0:       ra = 8'h0B;
        1:       ra = 8'(($urandom_range(0, 1) != 0) ? 32'h1B : 32'h1C);
        2:       ra = 8'($urandom_range(0, 255));
        default: ra = 8'(BASE + $urandom_range(0, NREG - 1));
      endcase
      rd    = 8'($urandom_range(0, 255));
      nb    = 16;
      ab_at = -1;
      w     = {16'd0, ra, rd};
      if (kind == 14) begin
        nb = 15;
        w  = {17'd0, ra, rd[6:0]};
      end else if (kind == 15) begin
        nb = 17;
        w  = {15'd0, ra, rd, rd[0]};
      end else if (kind == 16) begin
        ab_at = $urandom_range(1, 15);
      end
      run_frame("rnd", w, nb, ab_at, -1, (kind == 17), rb);
    end

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
